// File: rtl/ahb_sdram_arbiter.sv
// Two-client round-robin arbiter that serialises single-word req/ack requests
// into non-pipelined AHB-Lite SINGLE transfers toward the SDRAM slave port.
module ahb_sdram_arbiter #(
  parameter int ADDRESSWIDTH = 28,
  parameter int DATAWIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    c0_req,
  input  logic                    c0_write,
  input  logic [ADDRESSWIDTH-1:0] c0_addr,
  input  logic [DATAWIDTH-1:0]    c0_wdata,
  output logic                    c0_ack,
  output logic [DATAWIDTH-1:0]    c0_rdata,
  output logic                    c0_err,

  input  logic                    c1_req,
  input  logic                    c1_write,
  input  logic [ADDRESSWIDTH-1:0] c1_addr,
  input  logic [DATAWIDTH-1:0]    c1_wdata,
  output logic                    c1_ack,
  output logic [DATAWIDTH-1:0]    c1_rdata,
  output logic                    c1_err,

  output logic [ADDRESSWIDTH-1:0] HADDR,
  output logic [1:0]              HTRANS,
  output logic                    HWRITE,
  output logic [2:0]              HSIZE,
  output logic [2:0]              HBURST,
  output logic [DATAWIDTH-1:0]    HWDATA,
  input  logic [DATAWIDTH-1:0]    HRDATA,
  input  logic                    HREADY,
  input  logic                    HRESP,

  output logic                    owner,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [ADDRESSWIDTH-1:0] WORD_MASK = {{(ADDRESSWIDTH-2){1'b1}}, 2'b00};

  state_t state, next_state;

  logic                    last_grant;
  logic                    grant;
  logic                    grant_sel;
  logic                    xfer_owner;
  logic                    xfer_write;
  logic [ADDRESSWIDTH-1:0] xfer_addr;
  logic [DATAWIDTH-1:0]    xfer_wdata;
  logic [DATAWIDTH-1:0]    rdata_cap;
  logic                    err_cap;

  logic                    sel_write;
  logic [ADDRESSWIDTH-1:0] sel_addr;
  logic [DATAWIDTH-1:0]    sel_wdata;

  assign sel_write = grant_sel ? c1_write : c0_write;
  assign sel_addr  = grant_sel ? c1_addr  : c0_addr;
  assign sel_wdata = grant_sel ? c1_wdata : c0_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // When both clients are pending, the one not served last wins.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_sel  = 1'b0;
    HTRANS     = TRANS_IDLE;
    case (state)
      IDLE: begin
        if (c0_req || c1_req) begin
          grant      = 1'b1;
          grant_sel  = c0_req ? (c1_req ? ~last_grant : 1'b0) : 1'b1;
          next_state = ADDR;
        end
      end
      ADDR: begin
        HTRANS = TRANS_NONSEQ;
        if (HREADY) begin
          next_state = DATA;
        end
      end
      DATA: begin
        if (HREADY) begin
          next_state = RESP;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Transfer context is latched at grant so clients may change their inputs freely afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      xfer_owner <= 1'b0;
      xfer_write <= 1'b0;
      xfer_addr  <= '0;
      xfer_wdata <= '0;
      rdata_cap  <= '0;
      err_cap    <= 1'b0;
      c0_ack     <= 1'b0;
      c0_err     <= 1'b0;
      c0_rdata   <= '0;
      c1_ack     <= 1'b0;
      c1_err     <= 1'b0;
      c1_rdata   <= '0;
    end else begin
      c0_ack <= 1'b0;
      c0_err <= 1'b0;
      c1_ack <= 1'b0;
      c1_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            last_grant <= grant_sel;
            xfer_owner <= grant_sel;
            xfer_write <= sel_write;
            xfer_addr  <= sel_addr & WORD_MASK;
            xfer_wdata <= sel_wdata;
          end
        end
        DATA: begin
          if (HREADY) begin
            if (!xfer_write) begin
              rdata_cap <= HRDATA;
            end
            err_cap <= HRESP;
          end
        end
        RESP: begin
          if (xfer_owner) begin
            c1_ack <= 1'b1;
            c1_err <= err_cap;
            if (!xfer_write) begin
              c1_rdata <= rdata_cap;
            end
          end else begin
            c0_ack <= 1'b1;
            c0_err <= err_cap;
            if (!xfer_write) begin
              c0_rdata <= rdata_cap;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign HADDR  = xfer_addr;
  assign HWRITE = xfer_write;
  assign HWDATA = xfer_wdata;
  assign HSIZE  = 3'b010;
  assign HBURST = 3'b000;
  assign owner  = xfer_owner;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_ahb_sdram_arbiter.sv
// Bench for ahb_sdram_arbiter: a directed vector table, hand-written corner
// sequences, and randomized two-client traffic against a transaction model.
module tb_ahb_sdram_arbiter;
  localparam int AW = 28;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          c0_req, c0_write, c0_ack, c0_err;
  logic [AW-1:0] c0_addr;
  logic [DW-1:0] c0_wdata, c0_rdata;
  logic          c1_req, c1_write, c1_ack, c1_err;
  logic [AW-1:0] c1_addr;
  logic [DW-1:0] c1_wdata, c1_rdata;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE, HREADY, HRESP;
  logic [2:0]    HSIZE, HBURST;
  logic [DW-1:0] HWDATA, HRDATA;
  logic          owner, busy;

  int n_compared = 0;
  int n_mismatch = 0;

  always #5 clk = ~clk;

  ahb_sdram_arbiter #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c0_write(c0_write), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c0_err(c0_err),
    .c1_req(c1_req), .c1_write(c1_write), .c1_addr(c1_addr), .c1_wdata(c1_wdata),
    .c1_ack(c1_ack), .c1_rdata(c1_rdata), .c1_err(c1_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .owner(owner), .busy(busy)
  );

  typedef struct {
    logic          client;
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] hrdata;
    logic          hresp;
    logic          resp_wait;
    int            a_waits;
    int            d_waits;
    logic [AW-1:0] exp_haddr;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_lat;
  } vec_t;

  vec_t          vecs[7];
  vec_t          fresh;
  int            res_lat;
  logic [DW-1:0] res_rdata;
  logic          res_err;
  int            res_acycles;
  logic          res_other;

  // Transaction-level reference state for the random phase
  logic          m_in_addr, m_in_data, m_last, m_client, m_write, m_err, m_active;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata[2];
  int            m_ack_due;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic driveClient(input logic c, input logic req, input logic wr,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (c) begin
      c1_req = req; c1_write = wr; c1_addr = a; c1_wdata = d;
    end else begin
      c0_req = req; c0_write = wr; c0_addr = a; c0_wdata = d;
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    driveClient(1'b0, 1'b0, 1'b0, '0, '0);
    driveClient(1'b1, 1'b0, 1'b0, '0, '0);
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One transfer from an idle arbiter; the slave follows the vector's wait-state plan.
  task automatic applyStimulus(input vec_t v);
    int   last_data;
    logic ack_mine, ack_other;
    last_data = v.a_waits + v.d_waits + 1;
    res_lat = -1; res_rdata = '0; res_err = 1'b0; res_acycles = 0; res_other = 1'b0;
    driveClient(v.client, 1'b1, v.write, v.addr, v.wdata);
    @(posedge clk);
    for (int k = 0; k < 40 && res_lat < 0; k++) begin
      #1;
      ack_mine  = v.client ? c1_ack : c0_ack;
      ack_other = v.client ? c0_ack : c1_ack;
      if (ack_other) res_other = 1'b1;
      if (HTRANS == 2'b10) begin
        res_acycles++;
        checkOutput("haddr", HADDR, v.exp_haddr);
        checkOutput("hwrite", HWRITE, v.write);
        checkOutput("owner", owner, v.client);
      end
      if (v.write && k == last_data) checkOutput("hwdata", HWDATA, v.wdata);
      if (ack_mine) begin
        res_lat   = k;
        res_rdata = v.client ? c1_rdata : c0_rdata;
        res_err   = v.client ? c1_err : c0_err;
        driveClient(v.client, 1'b0, 1'b0, '0, '0);
      end else begin
        if (k == 0) driveClient(v.client, 1'b1, v.write, ~v.addr, ~v.wdata);
        if (k < v.a_waits) begin
          HREADY = 1'b0; HRESP = 1'b0; HRDATA = $urandom;
        end else if (k == v.a_waits) begin
          HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
        end else if (k < last_data) begin
          HREADY = 1'b0; HRESP = v.resp_wait; HRDATA = $urandom;
        end else if (k == last_data) begin
          HREADY = 1'b1; HRESP = v.hresp; HRDATA = v.hrdata;
        end else begin
          HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
        end
        @(posedge clk);
      end
    end
    HREADY = 1'b1; HRESP = 1'b0;
    @(posedge clk); #1;
    checkOutput("ack_width", {c1_ack, c0_ack}, 2'b00);
    checkOutput("idle_after_ack", busy, 1'b0);
  endtask

  task automatic randClient(input logic c, input logic mine_active);
    logic ack_now, req_now;
    ack_now = c ? c1_ack : c0_ack;
    req_now = c ? c1_req : c0_req;
    if (ack_now || !req_now) begin
      if ((ack_now && $urandom_range(0, 1) == 1) || (!ack_now && $urandom_range(0, 3) == 0))
        driveClient(c, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), $urandom);
      else
        driveClient(c, 1'b0, 1'b0, '0, '0);
    end else if (mine_active && $urandom_range(0, 2) == 0) begin
      driveClient(c, 1'b1, c ? c1_write : c0_write, AW'($urandom), $urandom);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: still running at t=%0t, limit 500000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   grants, acks0, acks1, last_k;
    logic ack_seen;

    vecs[0] = '{1'b0, 1'b0, 28'h0000010, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 0, 0, 28'h0000010, 32'hDEADBEEF, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b1, 28'h0000023, 32'h12345678, 32'hBAD0BAD0, 1'b0, 1'b0, 0, 0, 28'h0000020, 32'h00000000, 1'b0, 3};
    vecs[2] = '{1'b0, 1'b0, 28'h0ABCDE6, 32'h0,        32'hCAFEF00D, 1'b0, 1'b0, 2, 3, 28'h0ABCDE4, 32'hCAFEF00D, 1'b0, 8};
    vecs[3] = '{1'b0, 1'b0, 28'h0000100, 32'h0,        32'h11112222, 1'b1, 1'b1, 0, 1, 28'h0000100, 32'h11112222, 1'b1, 4};
    vecs[4] = '{1'b0, 1'b1, 28'h0FFFFFFF, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0, 0, 0, 28'h0FFFFFFC, 32'h11112222, 1'b0, 3};
    vecs[5] = '{1'b1, 1'b0, 28'h0000007, 32'h0,        32'h87654321, 1'b0, 1'b1, 0, 2, 28'h0000004, 32'h87654321, 1'b0, 5};
    vecs[6] = '{1'b1, 1'b1, 28'h0000030, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0, 1'b0, 1, 0, 28'h0000030, 32'h87654321, 1'b0, 4};
    fresh   = '{1'b1, 1'b0, 28'h0000302, 32'h0,        32'h600DF00D, 1'b0, 1'b0, 0, 0, 28'h0000300, 32'h600DF00D, 1'b0, 3};

    doReset();
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_htrans", HTRANS, 2'b00);
    checkOutput("rst_acks", {c1_ack, c0_ack}, 2'b00);
    checkOutput("rst_errs", {c1_err, c0_err}, 2'b00);
    checkOutput("rst_c0_rdata", c0_rdata, 32'h0);
    checkOutput("rst_c1_rdata", c1_rdata, 32'h0);
    checkOutput("rst_haddr", HADDR, 28'h0);
    checkOutput("rst_hwrite", HWRITE, 1'b0);
    checkOutput("rst_owner", owner, 1'b0);
    checkOutput("hsize", HSIZE, 3'b010);
    checkOutput("hburst", HBURST, 3'b000);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d_latency", i), res_lat, vecs[i].exp_lat);
      checkOutput($sformatf("v%0d_rdata", i), res_rdata, vecs[i].exp_rdata);
      checkOutput($sformatf("v%0d_err", i), res_err, vecs[i].exp_err);
      checkOutput($sformatf("v%0d_addr_cycles", i), res_acycles, vecs[i].a_waits + 1);
      checkOutput($sformatf("v%0d_other_ack", i), res_other, 1'b0);
    end

    // Contention from reset: both hold requests; c0 stops after two, c1 drops mid-transfer.
    doReset();
    driveClient(1'b0, 1'b1, 1'b0, 28'h0000040, 32'h0);
    driveClient(1'b1, 1'b1, 1'b1, 28'h0000080, 32'h00000055);
    grants = 0; acks0 = 0; acks1 = 0; last_k = 0;
    for (int k = 0; k < 40 && (acks0 + acks1) < 4; k++) begin
      @(posedge clk); #1;
      if (c0_ack) begin
        acks0++;
        if (acks0 == 2) driveClient(1'b0, 1'b0, 1'b0, '0, '0);
      end
      if (c1_ack) acks1++;
      if (HTRANS == 2'b10) begin
        checkOutput($sformatf("rr_owner%0d", grants), owner, grants % 2);
        checkOutput($sformatf("rr_haddr%0d", grants), HADDR, (grants % 2) ? 28'h0000080 : 28'h0000040);
        checkOutput($sformatf("rr_cycle%0d", grants), k, 4 * grants);
        grants++;
        last_k = k;
        if (grants == 4) driveClient(1'b1, 1'b0, 1'b0, '0, '0);
      end
    end
    checkOutput("rr_grants", grants, 4);
    checkOutput("rr_acks0", acks0, 2);
    checkOutput("rr_acks1", acks1, 2);
    checkOutput("rr_last_grant_cycle", last_k, 12);

    // Reset asserted while stalled in the data phase.
    doReset();
    driveClient(1'b0, 1'b1, 1'b0, 28'h0000200, 32'h0);
    @(posedge clk); #1;
    checkOutput("mid_htrans_addr", HTRANS, 2'b10);
    @(posedge clk); #1;
    checkOutput("mid_busy_data", busy, 1'b1);
    HREADY = 1'b0; reset = 1'b1;
    driveClient(1'b0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    checkOutput("mid_rst_busy", busy, 1'b0);
    checkOutput("mid_rst_htrans", HTRANS, 2'b00);
    checkOutput("mid_rst_ack", c0_ack, 1'b0);
    reset = 1'b0; HREADY = 1'b1;
    ack_seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (c0_ack || c1_ack) ack_seen = 1'b1;
    end
    checkOutput("mid_rst_no_ack", ack_seen, 1'b0);
    applyStimulus(fresh);
    checkOutput("fresh_latency", res_lat, fresh.exp_lat);
    checkOutput("fresh_rdata", res_rdata, fresh.exp_rdata);
    checkOutput("fresh_err", res_err, fresh.exp_err);

    // Randomized traffic checked cycle by cycle against the transaction model.
    doReset();
    m_in_addr = 1'b0; m_in_data = 1'b0; m_last = 1'b1; m_client = 1'b0; m_write = 1'b0;
    m_err = 1'b0; m_addr = '0; m_wdata = '0; m_rdata[0] = '0; m_rdata[1] = '0; m_ack_due = -1;
    for (int k = 0; k < 3000; k++) begin
      checkOutput("rnd_ack0", c0_ack, (m_ack_due == k) && !m_client);
      checkOutput("rnd_ack1", c1_ack, (m_ack_due == k) && m_client);
      checkOutput("rnd_htrans", HTRANS, m_in_addr ? 2'b10 : 2'b00);
      checkOutput("rnd_busy", busy, m_in_addr || m_in_data || (m_ack_due == k + 1));
      if (m_in_addr) begin
        checkOutput("rnd_haddr", HADDR, m_addr);
        checkOutput("rnd_hwrite", HWRITE, m_write);
        checkOutput("rnd_owner", owner, m_client);
      end
      if (m_in_data && m_write) checkOutput("rnd_hwdata", HWDATA, m_wdata);
      if (m_ack_due == k) begin
        checkOutput("rnd_rdata", m_client ? c1_rdata : c0_rdata, m_rdata[m_client]);
        checkOutput("rnd_err", m_client ? c1_err : c0_err, m_err);
      end

      m_active = m_in_addr || m_in_data || (m_ack_due == k + 1);
      randClient(1'b0, m_active && !m_client);
      randClient(1'b1, m_active && m_client);
      HREADY = ($urandom_range(0, 9) < 7);
      HRESP  = ($urandom_range(0, 4) == 0);
      HRDATA = $urandom;

      if (!m_active) begin
        if (c0_req || c1_req) begin
          if (c0_req && c1_req) m_client = !m_last;
          else                  m_client = c1_req;
          m_last    = m_client;
          m_write   = m_client ? c1_write : c0_write;
          m_addr    = (m_client ? c1_addr : c0_addr) & ~AW'(3);
          m_wdata   = m_client ? c1_wdata : c0_wdata;
          m_in_addr = 1'b1;
        end
      end else if (m_in_addr) begin
        if (HREADY) begin
          m_in_addr = 1'b0;
          m_in_data = 1'b1;
        end
      end else if (m_in_data) begin
        if (HREADY) begin
          m_in_data = 1'b0;
          m_err     = HRESP;
          if (!m_write) m_rdata[m_client] = HRDATA;
          m_ack_due = k + 2;
        end
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end
endmodule

// File: doc/ahb_sdram_arbiter.md
Name: ahb_sdram_arbiter

Overview:
Two-client round-robin arbiter that shares the single AHB-Lite path into the PCIe/SDRAM subsystem. Each client issues single-word read/write requests over a simple req/ack interface. The arbiter serialises these requests into non-pipelined AHB-Lite SINGLE transfers. It sits between on-chip requesters (e.g. display refresh logic, a test pattern engine) and the slave port in front of the SDRAM controller.

Parameters:
ADDRESSWIDTH, 28, width of client and AHB byte addresses.
DATAWIDTH, 32, width of read/write data; transfers are always full-word.

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
c0_req  in  1  client 0 request; held high until c0_ack.
c0_write  in  1  client 0 direction: 1 = write, 0 = read.
c0_addr  in  ADDRESSWIDTH  client 0 byte address.
c0_wdata  in  DATAWIDTH  client 0 write data.
c0_ack  out  1  one-cycle completion pulse for client 0.
c0_rdata  out  DATAWIDTH  client 0 read data; valid while c0_ack = 1.
c0_err  out  1  error flag; valid with c0_ack.
c1_req, c1_write, c1_addr, c1_wdata, c1_ack, c1_rdata, c1_err: same as client 0, for client 1.
HADDR  out  ADDRESSWIDTH  AHB address.
HTRANS  out  2  AHB transfer type; only IDLE (00) and NONSEQ (10) are used.
HWRITE  out  1  AHB write.
HSIZE  out  3  constant 3'b010 (word).
HBURST  out  3  constant 3'b000 (SINGLE).
HWDATA  out  DATAWIDTH  AHB write data.
HRDATA  in  DATAWIDTH  AHB read data.
HREADY  in  1  AHB ready.
HRESP  in  1  AHB response; 1 = ERROR.
owner  out  1  client currently granted; only meaningful when busy = 1.
busy  out  1  1 in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state = IDLE, last_grant = 1 (so client 0 wins the first tie), all outputs 0. HSIZE and HBURST keep their constant values.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: HTRANS = 00.
  - Only one request pending: grant that client.
  - Both requests pending: grant the client that is not last_grant.
  - On grant, latch owner, write, addr (bits [1:0] forced to 0) and wdata. Update last_grant. Go to ADDR.
- ADDR: HTRANS = 10, with HADDR and HWRITE driven from the latched values.
  - HREADY = 1: go to DATA.
  - HREADY = 0: stay in ADDR, holding every address-phase signal stable.
- DATA: HTRANS = 00; HWDATA driven from the latched wdata.
  - HREADY = 1: capture HRDATA (reads only) and HRESP into registers. Go to RESP.
  - HREADY = 0: stay in DATA.
  - HRESP = 1 with HREADY = 0 (first cycle of a two-cycle ERROR response): ignored; only the HREADY = 1 cycle is sampled.
- RESP: owner's ack = 1 for exactly one cycle, with that client's rdata and err valid. Go to IDLE unconditionally.
- Registered outputs: ack, rdata and err are registered. rdata holds its last value otherwise. The non-owner's ack and err stay 0.
- Latency: with HREADY tied high, ack is asserted 3 cycles after the edge at which req is sampled in IDLE. Peak throughput is one transfer per 4 cycles.
- Client rules: a client keeps req high until it sees ack, then drops it or immediately presents its next request.
  - req dropped mid-transfer: the AHB transfer still completes and ack is still pulsed.
  - addr/wdata changed after grant: no effect on the transfer in progress.
- Write data is HWDATA only. HRDATA is ignored on writes, and rdata is not updated.
- Fairness: with both clients continuously requesting, grants strictly alternate 0,1,0,1…
- Reset mid-transfer: on the next edge all state returns to reset values and HTRANS = 00. No ack is generated for the aborted transfer.
- No timeout: a slave that never raises HREADY holds the FSM in ADDR or DATA indefinitely.

Test Plan:
- Single read: c0 reads 0x0000010, HREADY = 1, HRDATA = 0xDEADBEEF → HTRANS = 10 for 1 cycle, HADDR = 0x0000010, HWRITE = 0; c0_ack pulses 3 cycles after req with c0_rdata = 0xDEADBEEF and c0_err = 0.
- Single write: c1 writes 0x12345678 to 0x0000023 → HADDR = 0x0000020, HWRITE = 1, HWDATA = 0x12345678 in the data phase; c1_ack = 1 for one cycle; c0_ack stays 0.
- Contention after reset: c0 and c1 request in the same cycle, both held → grant order 0,1,0,1 over 4 transfers; owner toggles on each grant.
- Wait states: HREADY low for 2 cycles in ADDR and 3 cycles in DATA → HADDR and HTRANS stable while stalled; ack arrives 3 + 5 = 8 cycles after req.
- Error response: HRESP = 1 with HREADY = 0, then HRESP = 1 with HREADY = 1 in DATA → c0_err = 1 together with c0_ack; the next transfer returns err = 0.
- Reset mid-operation: assert reset while in DATA → next cycle busy = 0 and HTRANS = 00; no ack occurs; a fresh c1 request after reset completes normally.
